// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 16-byte lines.
// Hits complete combinationally; misses run WB -> MEM_RD -> UPDATE against a 128-bit memory port.
module data_cache #(
    parameter int NUM_SETS = 8
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic [3:0]   READ,
    input  logic [2:0]   WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITE_DATA,
    output logic [31:0]  READ_DATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WB, MEM_RD, UPDATE} state_t;
    state_t state_reg, state_next;

    logic [NUM_SETS-1:0] valid_reg, dirty_reg;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [127:0]        data_mem [NUM_SETS];
    logic [31:0]         read_data_reg;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word_sel;
    logic             req, store, load, hit, load_hit, store_hit;
    logic [127:0]     line, store_line;
    logic [31:0]      cur_word, store_word, load_value;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [3:0]       byte_en;

    assign tag       = ADDRESS[31:4+IDX_W];
    assign idx       = ADDRESS[3+IDX_W:4];
    assign word_sel  = ADDRESS[3:2];
    assign req       = READ[3] | WRITE[2];
    assign store     = WRITE[2];
    assign load      = READ[3] & ~WRITE[2];
    assign hit       = valid_reg[idx] && (tag_mem[idx] == tag);
    assign load_hit  = load && hit;
    assign store_hit = (state_reg == IDLE) && store && hit;
    assign line      = data_mem[idx];
    assign cur_word  = line[{word_sel, 5'b0} +: 32];

    // Per byte lane: enable and source byte for SB/SH/SW (the half's low address bit is ignored).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_data;
            assign byte_en[gi] = (WRITE[1:0] == 2'b00) ? (ADDRESS[1:0] == 2'(gi)) :
                                 (WRITE[1:0] == 2'b01) ? (ADDRESS[1] == 1'(gi / 2)) : 1'b1;
            assign lane_data   = (WRITE[1:0] == 2'b00) ? WRITE_DATA[7:0] :
                                 (WRITE[1:0] == 2'b01) ? WRITE_DATA[8*(gi%2) +: 8] :
                                                         WRITE_DATA[8*gi +: 8];
            assign store_word[8*gi +: 8] = byte_en[gi] ? lane_data : cur_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        store_line = line;
        store_line[{word_sel, 5'b0} +: 32] = store_word;
    end

    assign byte_sel = cur_word[{ADDRESS[1:0], 3'b0} +: 8];
    assign half_sel = cur_word[{ADDRESS[1], 4'b0} +: 16];

    always_comb begin
        case (READ[2:0])
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_value = {24'b0, byte_sel};
            3'b101:  load_value = {16'b0, half_sel};
            default: load_value = cur_word;
        endcase
    end

    assign READ_DATA = load_hit ? load_value : read_data_reg;
    // Gated by reset so a stalled request reads as idle while the cache is held in reset.
    assign BUSYWAIT  = RESET_N && ((state_reg != IDLE) || (req && !hit));

    always_comb begin
        state_next    = state_reg;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state_reg)
            IDLE: begin
                if (req && !hit)
                    state_next = dirty_reg[idx] ? WB : MEM_RD;
            end
            WB: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_mem[idx], idx};
                MEM_WRITEDATA = line;
                if (!MEM_BUSYWAIT)
                    state_next = MEM_RD;
            end
            MEM_RD: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[31:4];
                if (!MEM_BUSYWAIT)
                    state_next = UPDATE;
            end
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= IDLE;
            valid_reg     <= '0;
            dirty_reg     <= '0;
            read_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_hit)
                read_data_reg <= load_value;
            if (state_reg == UPDATE) begin
                valid_reg[idx] <= 1'b1;
                dirty_reg[idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_reg[idx] <= 1'b1;
            end
        end
    end

    // Line storage is never reset; validity alone decides whether contents matter.
    always_ff @(posedge CLK) begin
        if (state_reg == UPDATE) begin
            data_mem[idx] <= MEM_READDATA;
            tag_mem[idx]  <= tag;
        end else if (store_hit) begin
            data_mem[idx] <= store_line;
        end
    end
endmodule
